// File: rtl/key_event_queue_if.sv
// Bus between the key-scan event source / CPU IO side and the key event queue.
// The queue takes the slave modport; the driving side takes the master modport.
interface key_event_queue_if #(
   parameter int AW = 3
);
   logic          ev_valid;
   logic [31:0]   ev_data;
   logic          rd;
   logic          clr;
   logic [31:0]   rd_data;
   logic [AW:0]   count;
   logic          empty;
   logic          full;
   logic          overflow;
   logic          irq;
   logic          pend;

   modport slave (
      input  ev_valid, ev_data, rd, clr,
      output rd_data, count, empty, full, overflow, irq, pend
   );

   modport master (
      output ev_valid, ev_data, rd, clr,
      input  rd_data, count, empty, full, overflow, irq, pend
   );
endinterface

// File: rtl/key_event_queue.sv
// Timestamped FIFO for key-scan events: stamps, buffers and presents events to the CPU
// with pop/flush controls, occupancy/overflow status and interrupts.
module key_event_queue #(
   parameter int DEPTH    = 8,
   parameter int AW       = 3,
   parameter int TICK_DIV = 50000
) (
   input  logic             clk,
   input  logic             rst,
   key_event_queue_if.slave bus
);
   localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [AW:0]    DEPTH_C   = (AW + 1)'(DEPTH);

   logic [31:0]   mem [DEPTH];

   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   ts_q, ts_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          empty_q, empty_d;
   logic          full_q, full_d;
   logic          ovf_q, ovf_d;
   logic          irq_q, irq_d;

   logic          accept;
   logic          do_push;
   logic          do_pop;
   logic          drop;
   logic [31:0]   wr_word;
   logic          unused_ev_bits;

   assign unused_ev_bits = ^bus.ev_data[23:5];

   // A full queue still accepts when the same-cycle pop frees the head slot.
   assign accept  = bus.ev_valid & (|bus.ev_data[4:0]) & ~bus.clr;
   assign do_pop  = bus.rd & ~empty_q & ~bus.clr;
   assign do_push = accept & (~full_q | bus.rd);
   assign drop    = accept & full_q & ~bus.rd;
   assign wr_word = {bus.ev_data[31:24], ts_q, 3'b000, bus.ev_data[4:0]};

   always_comb begin
      presc_d = presc_q + PW'(1);
      ts_d    = ts_q;
      if (presc_q == PRESC_MAX) begin
         presc_d = '0;
         ts_d    = ts_q + 16'd1;
      end

      wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
      ovf_d = ovf_q | drop;
      irq_d = do_push;

      if (bus.clr) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
         ovf_d   = 1'b0;
         irq_d   = 1'b0;
      end

      empty_d = (count_d == '0);
      full_d  = (count_d == DEPTH_C);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         ts_q    <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         presc_q <= presc_d;
         ts_q    <= ts_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         ovf_q   <= ovf_d;
         irq_q   <= irq_d;
      end
   end

   // Storage has no reset; contents behind the pointers are never observed.
   always_ff @(posedge clk) begin
      if (do_push && !rst) begin
         mem[wptr_q] <= wr_word;
      end
   end

   assign bus.rd_data  = empty_q ? 32'd0 : mem[rptr_q];
   assign bus.count    = count_q;
   assign bus.empty    = empty_q;
   assign bus.full     = full_q;
   assign bus.overflow = ovf_q;
   assign bus.irq      = irq_q;
   assign bus.pend     = ~empty_q;
endmodule

// File: tb/tb_key_event_queue.sv
// Scoreboard bench for key_event_queue: a queue-based reference model predicts the
// outputs after every clock edge and a monitor compares them against the DUT.
module tb_key_event_queue;
   localparam int DEPTH    = 8;
   localparam int AW       = 3;
   localparam int TICK_DIV = 4;

   typedef struct {
      logic [31:0] rd_data;
      logic [AW:0] count;
      logic        empty;
      logic        full;
      logic        ovf;
      logic        irq;
      logic        pend;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   key_event_queue_if #(.AW(AW)) bus ();

   key_event_queue #(.DEPTH(DEPTH), .AW(AW), .TICK_DIV(TICK_DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;
   exp_t        exq[$];
   logic [31:0] mq[$];
   logic        m_ovf  = 1'b0;
   logic        m_irq  = 1'b0;
   int          m_tick = 0;

   // Reference model: a plain queue of stored words; ts derived from elapsed cycles.
   always @(posedge clk) begin
      exp_t e;
      logic acc;
      if (rst) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_irq  = 1'b0;
         m_tick = 0;
      end else begin
         m_irq = 1'b0;
         if (bus.clr) begin
            mq.delete();
            m_ovf = 1'b0;
         end else begin
            acc = bus.ev_valid && (bus.ev_data[4:0] != 5'd0);
            if (acc && mq.size() == DEPTH && !bus.rd) begin
               m_ovf = 1'b1;
            end else begin
               if (bus.rd && mq.size() > 0) void'(mq.pop_front());
               if (acc) begin
                  mq.push_back({bus.ev_data[31:24], 16'(m_tick / TICK_DIV), 3'b000, bus.ev_data[4:0]});
                  m_irq = 1'b1;
               end
            end
         end
         m_tick++;
      end
      e.rd_data = (mq.size() > 0) ? mq[0] : 32'd0;
      e.count   = (AW + 1)'(mq.size());
      e.empty   = (mq.size() == 0);
      e.full    = (mq.size() == DEPTH);
      e.ovf     = m_ovf;
      e.irq     = m_irq;
      e.pend    = (mq.size() != 0);
      exq.push_back(e);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
      end
   endtask

   // Monitor: after each edge, pop the prediction and compare every output.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exq.size() > 0) begin
         e = exq.pop_front();
         chk("rd_data",  bus.rd_data,          e.rd_data);
         chk("count",    32'(bus.count),       32'(e.count));
         chk("empty",    32'(bus.empty),       32'(e.empty));
         chk("full",     32'(bus.full),        32'(e.full));
         chk("overflow", 32'(bus.overflow),    32'(e.ovf));
         chk("irq",      32'(bus.irq),         32'(e.irq));
         chk("pend",     32'(bus.pend),        32'(e.pend));
      end
   end

   task automatic step(input logic v, input logic [31:0] d, input logic r, input logic c);
      @(negedge clk);
      rst          = 1'b0;
      bus.ev_valid = v;
      bus.ev_data  = d;
      bus.rd       = r;
      bus.clr      = c;
   endtask

   task automatic ev(input logic [7:0] typ, input logic [4:0] key, input logic r);
      step(1'b1, {typ, 19'h5A5A5, key}, r, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0);
   endtask

   initial begin
      bus.ev_valid = 1'b0;
      bus.ev_data  = 32'd0;
      bus.rd       = 1'b0;
      bus.clr      = 1'b0;
      rst          = 1'b1;
      repeat (2) @(negedge clk);

      // Idle after reset, then an event captured at ts=7.
      idle(3);
      while (m_tick < 28) idle(1);
      step(1'b1, 32'h0100_0004, 1'b0, 1'b0);
      idle(2);
      step(1'b0, 32'd0, 1'b1, 1'b0);
      idle(2);

      // Nine events into an eight-entry queue, then drain across the wrap.
      for (int k = 1; k <= 9; k++) ev(8'(k + 16), 5'(k), 1'b0);
      idle(1);
      for (int k = 0; k < 9; k++) step(1'b0, 32'd0, 1'b1, 1'b0);

      // Full queue with simultaneous event and pop; overflow must stay clear.
      step(1'b0, 32'd0, 1'b0, 1'b1);
      for (int k = 1; k <= 8; k++) ev(8'h22, 5'(k + 3), 1'b0);
      ev(8'h33, 5'd31, 1'b1);
      idle(1);
      for (int k = 0; k < 8; k++) step(1'b0, 32'd0, 1'b1, 1'b0);

      // Pop on empty and key=0 events are no-ops; empty queue with push+rd.
      step(1'b0, 32'd0, 1'b1, 1'b0);
      step(1'b1, 32'hFF00_0000, 1'b0, 1'b0);
      step(1'b1, 32'hFF00_0000, 1'b1, 1'b0);
      ev(8'h44, 5'd9, 1'b1);
      step(1'b0, 32'd0, 1'b1, 1'b0);

      // Flush with event and pop on a 3-entry queue with overflow set.
      for (int k = 1; k <= 9; k++) ev(8'h55, 5'(k), 1'b0);
      for (int k = 0; k < 5; k++) step(1'b0, 32'd0, 1'b1, 1'b0);
      step(1'b1, 32'h6600_0007, 1'b1, 1'b1);
      idle(5);
      ev(8'h77, 5'd3, 1'b0);
      idle(2);

      // Randomized traffic with shifting pop pressure, occasional flush and reset.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] d;
         int          rd_pct;
         rd_pct = (i < 1000) ? 15 : ((i < 2000) ? 50 : 80);
         d      = $urandom;
         if ($urandom_range(0, 7) == 0) d[4:0] = 5'd0;
         step($urandom_range(0, 99) < 40, d, $urandom_range(0, 99) < rd_pct,
              $urandom_range(0, 99) == 0);
         if ($urandom_range(0, 599) == 0) begin
            @(negedge clk);
            rst = 1'b1;
         end
      end

      idle(3);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
